// File: rtl/signal_generator_dds_pkg.sv
// Shared constants, tone-select encodings and the quarter-wave sine table
// for the two-tone DDS test-signal source.
package signal_generator_dds_pkg;

    localparam int NB_DATA     = 8;
    localparam int NB_PHASE    = 16;
    localparam int NB_LUT_ADDR = 6;
    localparam int LUT_DEPTH   = 1 << NB_LUT_ADDR;
    localparam int NB_MAG      = NB_DATA - 1;
    localparam int AMP         = 127;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_AVG  = 2'b10,
        SEL_ZERO = 2'b11
    } tone_sel_t;

    // round(127*sin(pi/2*(k+0.5)/64)); the half-step offset keeps 0 and -128 off the output
    localparam logic [NB_MAG-1:0] SINE_LUT [LUT_DEPTH] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

endpackage

// File: rtl/signal_generator_dds_if.sv
// Control and sample bus between the DDS source and its consumer.
interface signal_generator_dds_if;
    import signal_generator_dds_pkg::*;

    logic                       i_enable;
    logic                       i_phase_clr;
    logic [NB_PHASE-1:0]        i_tune_a;
    logic [NB_PHASE-1:0]        i_tune_b;
    logic [1:0]                 i_tone_sel;
    logic signed [NB_DATA-1:0]  o_signal;
    logic                       o_valid;

    modport master (
        output i_enable, i_phase_clr, i_tune_a, i_tune_b, i_tone_sel,
        input  o_signal, o_valid
    );

    modport slave (
        input  i_enable, i_phase_clr, i_tune_a, i_tune_b, i_tone_sel,
        output o_signal, o_valid
    );

endinterface

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine lookup: folds a quadrant/index address onto the table and
// presents the signed sample two clocks after launch.
module dds_sine_lut
    import signal_generator_dds_pkg::*;
(
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        launch,
    input  logic [NB_LUT_ADDR+1:0]      addr,
    output logic signed [NB_DATA-1:0]   tone
);

    logic [NB_LUT_ADDR-1:0] idx_p1;
    logic                   neg_p1;
    logic [NB_MAG-1:0]      mag_p2;
    logic                   neg_p2;

    // Odd quadrants walk the table backwards; 63-idx is the bitwise complement
    function automatic logic [NB_LUT_ADDR-1:0] fold_idx(input logic [NB_LUT_ADDR+1:0] a);
        return a[NB_LUT_ADDR] ? ~a[NB_LUT_ADDR-1:0] : a[NB_LUT_ADDR-1:0];
    endfunction

    function automatic logic signed [NB_DATA-1:0] apply_sign(input logic neg,
                                                             input logic [NB_MAG-1:0] mag);
        logic signed [NB_DATA-1:0] m;
        m = {1'b0, mag};
        return neg ? -m : m;
    endfunction

    // S1: folded address and sign
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            idx_p1 <= '0;
            neg_p1 <= 1'b0;
        end else if (launch) begin
            idx_p1 <= fold_idx(addr);
            neg_p1 <= addr[NB_LUT_ADDR+1];
        end
    end

    // S2: table read
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mag_p2 <= '0;
            neg_p2 <= 1'b0;
        end else begin
            mag_p2 <= SINE_LUT[idx_p1];
            neg_p2 <= neg_p1;
        end
    end

    assign tone = apply_sign(neg_p2, mag_p2);

endmodule

// File: rtl/signal_generator_dds.sv
// Two-tone DDS source: sample-rate divider, two phase accumulators, two sine
// lookups and a tone select/average output stage with a one-cycle valid.
module signal_generator_dds
    import signal_generator_dds_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic                   clock,
    input logic                   i_reset,
    signal_generator_dds_if.slave bus
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]          cnt;
    logic                      strobe_p0;
    logic [NB_PHASE-1:0]       phase_a;
    logic [NB_PHASE-1:0]       phase_b;
    logic                      vld_p1;
    logic                      vld_p2;
    logic signed [NB_DATA-1:0] tone_a_p2;
    logic signed [NB_DATA-1:0] tone_b_p2;
    logic signed [NB_DATA-1:0] signal_p3;
    logic                      valid_p3;

    // Floor average; the 9-bit sum of two +/-127 values cannot overflow
    function automatic logic signed [NB_DATA-1:0] avg_floor(input logic signed [NB_DATA-1:0] a,
                                                            input logic signed [NB_DATA-1:0] b);
        logic signed [NB_DATA:0] sum;
        logic signed [NB_DATA:0] half;
        sum  = {a[NB_DATA-1], a} + {b[NB_DATA-1], b};
        half = sum >>> 1;
        return half[NB_DATA-1:0];
    endfunction

    function automatic logic signed [NB_DATA-1:0] select_tone(input tone_sel_t sel,
                                                              input logic signed [NB_DATA-1:0] a,
                                                              input logic signed [NB_DATA-1:0] b);
        case (sel)
            SEL_A:   return a;
            SEL_B:   return b;
            SEL_AVG: return avg_floor(a, b);
            default: return '0;
        endcase
    endfunction

    // S0: sample-rate divider; the strobe is registered so launch follows one edge later
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt       <= '0;
            strobe_p0 <= 1'b0;
        end else begin
            strobe_p0 <= 1'b0;
            if (bus.i_enable) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    strobe_p0 <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Clear wins over the advance; the lookups still launch from the pre-clear phase
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            phase_a <= '0;
            phase_b <= '0;
        end else if (bus.i_phase_clr) begin
            phase_a <= '0;
            phase_b <= '0;
        end else if (strobe_p0) begin
            phase_a <= phase_a + bus.i_tune_a;
            phase_b <= phase_b + bus.i_tune_b;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= strobe_p0;
            vld_p2 <= vld_p1;
        end
    end

    dds_sine_lut u_lut_a (
        .clock  (clock),
        .rst_n  (i_reset),
        .launch (strobe_p0),
        .addr   (phase_a[NB_PHASE-1 -: NB_LUT_ADDR+2]),
        .tone   (tone_a_p2)
    );

    dds_sine_lut u_lut_b (
        .clock  (clock),
        .rst_n  (i_reset),
        .launch (strobe_p0),
        .addr   (phase_b[NB_PHASE-1 -: NB_LUT_ADDR+2]),
        .tone   (tone_b_p2)
    );

    // S3: tone select / average, output holds between valid pulses
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            signal_p3 <= '0;
            valid_p3  <= 1'b0;
        end else begin
            valid_p3 <= vld_p2;
            if (vld_p2) begin
                signal_p3 <= select_tone(tone_sel_t'(bus.i_tone_sel), tone_a_p2, tone_b_p2);
            end
        end
    end

    assign bus.o_signal = signal_p3;
    assign bus.o_valid  = valid_p3;

endmodule
